// File: rtl/spi_shift_pkg.sv
// spi_pkg: sizes and state encoding shared by the SPI serial stage,
// the clock generator and the Wishbone front end.
package spi_pkg;
  localparam int MAX_CHAR = 32;
  localparam int LEN_W    = 5;
  localparam int BSEL_W   = MAX_CHAR / 8;

  typedef enum logic {
    SPI_IDLE  = 1'b0,
    SPI_SHIFT = 1'b1
  } spi_state_e;
endpackage

// File: rtl/spi_shift_if.sv
// spi_shift_if: control, strobe and data bundle of the SPI serial stage.
// master = control/clock side, slave = spi_shift.
interface spi_shift_if;
  import spi_pkg::*;

  logic              go;
  logic              latch;
  logic [BSEL_W-1:0] byte_sel;
  logic [MAX_CHAR-1:0] p_in;
  logic [LEN_W-1:0]  len;
  logic              lsb;
  logic              tx_negedge;
  logic              rx_negedge;
  logic              cpol_0;
  logic              cpol_1;
  logic              miso;
  logic              tip;
  logic              lstclk;
  logic              done;
  logic              mosi;
  logic [MAX_CHAR-1:0] p_out;

  modport master (
    output go, latch, byte_sel, p_in, len, lsb,
    output tx_negedge, rx_negedge, cpol_0, cpol_1, miso,
    input  tip, lstclk, done, mosi, p_out
  );

  modport slave (
    input  go, latch, byte_sel, p_in, len, lsb,
    input  tx_negedge, rx_negedge, cpol_0, cpol_1, miso,
    output tip, lstclk, done, mosi, p_out
  );
endinterface

// File: rtl/spi_shift.sv
// spi_shift: SPI data register, shifted out on mosi and refilled from miso.
// Define SPI_SHIFT_LSB_EN to honour lsb; otherwise always MSB first.
module spi_shift
  import spi_pkg::*;
(
  input logic        wb_clk,
  input logic        wb_reset_n,
  spi_shift_if.slave bus
);

  localparam logic [LEN_W:0] ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] ZERO = (LEN_W+1)'(0);
  localparam logic [LEN_W:0] FULL = (LEN_W+1)'(MAX_CHAR);

  spi_state_e          r_state;
  logic [MAX_CHAR-1:0] r_data;
  logic [MAX_CHAR-1:0] w_merged;
  logic [LEN_W:0]      r_len;
  logic [LEN_W:0]      r_tx_cnt;
  logic [LEN_W:0]      r_rx_cnt;
  logic [LEN_W:0]      w_len;
  logic                r_txn;
  logic                r_rxn;
  logic                r_mosi;
  logic                r_done;
  logic                w_tip;
  logic                w_tx_clk;
  logic                w_rx_clk;
  logic                w_lsb_go;
  logic                w_lsb_run;

  function automatic logic [LEN_W-1:0] bit_idx(
    input logic [LEN_W:0] c,
    input logic [LEN_W:0] l,
    input logic           lsb_first
  );
    logic [LEN_W:0] t;
    t = lsb_first ? c : (l - c - ONE);
    return t[LEN_W-1:0];
  endfunction

`ifdef SPI_SHIFT_LSB_EN
  logic r_lsb;

  always_ff @(posedge wb_clk) begin
    if (!wb_reset_n)
      r_lsb <= 1'b0;
    else if (!w_tip && bus.go)
      r_lsb <= bus.lsb;
  end

  assign w_lsb_go  = bus.lsb;
  assign w_lsb_run = r_lsb;
`else
  assign w_lsb_go  = 1'b0;
  assign w_lsb_run = 1'b0;
`endif

  assign w_len    = (bus.len == '0) ? FULL : {1'b0, bus.len};
  assign w_tip    = (r_state == SPI_SHIFT);
  assign w_tx_clk = r_txn ? bus.cpol_1 : bus.cpol_0;
  assign w_rx_clk = r_rxn ? bus.cpol_1 : bus.cpol_0;

  // Byte-enable merge; the preloaded first bit comes from this view.
  always_comb begin
    w_merged = r_data;
    for (int b = 0; b < BSEL_W; b++)
      if (bus.latch && bus.byte_sel[b])
        w_merged[b*8 +: 8] = bus.p_in[b*8 +: 8];
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_reset_n) begin
      r_state  <= SPI_IDLE;
      r_data   <= '0;
      r_len    <= ZERO;
      r_tx_cnt <= ZERO;
      r_rx_cnt <= ZERO;
      r_txn    <= 1'b0;
      r_rxn    <= 1'b0;
      r_mosi   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        SPI_IDLE: begin
          r_data <= w_merged;
          if (bus.go) begin
            r_state  <= SPI_SHIFT;
            r_len    <= w_len;
            r_txn    <= bus.tx_negedge;
            r_rxn    <= bus.rx_negedge;
            r_rx_cnt <= ZERO;
            if (bus.tx_negedge) begin
              r_mosi   <= w_merged[bit_idx(ZERO, w_len, w_lsb_go)];
              r_tx_cnt <= ONE;
            end else begin
              r_tx_cnt <= ZERO;
            end
          end
        end
        SPI_SHIFT: begin
          if (w_tx_clk && (r_tx_cnt < r_len)) begin
            r_mosi   <= r_data[bit_idx(r_tx_cnt, r_len, w_lsb_run)];
            r_tx_cnt <= r_tx_cnt + ONE;
          end
          if (w_rx_clk) begin
            r_data[bit_idx(r_rx_cnt, r_len, w_lsb_run)] <= bus.miso;
            // Final sample: counter clears override the tx increment.
            if (r_rx_cnt == r_len - ONE) begin
              r_state  <= SPI_IDLE;
              r_done   <= 1'b1;
              r_tx_cnt <= ZERO;
              r_rx_cnt <= ZERO;
            end else begin
              r_rx_cnt <= r_rx_cnt + ONE;
            end
          end
        end
        default: r_state <= SPI_IDLE;
      endcase
    end
  end

  assign bus.tip    = w_tip;
  assign bus.lstclk = w_tip && (r_tx_cnt == r_len);
  assign bus.done   = r_done;
  assign bus.mosi   = r_mosi;
  assign bus.p_out  = r_data;

endmodule

// File: tb/tb_spi_shift.sv
// tb_spi_shift: randomized bench for spi_shift against a bit-list model.
// Honours SPI_SHIFT_LSB_EN the same way the design does.
`timescale 1ns/1ps
module tb_spi_shift;
  import spi_pkg::*;

`ifdef SPI_SHIFT_LSB_EN
  localparam bit LSB_ON = 1'b1;
`else
  localparam bit LSB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_shift_if bus();

  spi_shift dut (
    .wb_clk     (clk),
    .wb_reset_n (rst_n),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [MAX_CHAR-1:0] m_reg = '0;

  function automatic int eff_len(input int len);
    return (len == 0) ? MAX_CHAR : len;
  endfunction

  function automatic int bidx(input int k, input int l, input bit lsb);
    return (lsb && LSB_ON) ? k : (l - 1 - k);
  endfunction

  function automatic logic [MAX_CHAR-1:0] merge(
    input logic [MAX_CHAR-1:0] cur,
    input logic [MAX_CHAR-1:0] pin,
    input logic [BSEL_W-1:0] bs
  );
    logic [MAX_CHAR-1:0] r;
    r = cur;
    for (int b = 0; b < BSEL_W; b++)
      if (bs[b]) r[b*8 +: 8] = pin[b*8 +: 8];
    return r;
  endfunction

  // Runs one transfer from the current negedge; returns on the done cycle.
  // miso_mode: 0 random, 1 loopback, 2 tied high.
  task automatic run_xfer(
    input string nm, input logic [MAX_CHAR-1:0] pin,
    input logic [BSEL_W-1:0] bsel, input bit lat,
    input int len, input bit lsb, input bit txn, input bit rxn,
    input int miso_mode, input bit disturb,
    input int both_k, input int abort_at
  );
    int L, n_tx, n_rx, s, cyc, ndone;
    bit q[$];
    bit c0, c1, ph, tx, rx, did_tx, mb, aborted, dd;
    L = eff_len(len);
    if (lat) m_reg = merge(m_reg, pin, bsel);
    q = {};
    for (int k = 0; k < L; k++) q.push_back(m_reg[bidx(k, L, lsb)]);
    bus.go = 1'b1; bus.latch = lat; bus.byte_sel = bsel;
    bus.p_in = pin; bus.len = len[LEN_W-1:0]; bus.lsb = lsb;
    bus.tx_negedge = txn; bus.rx_negedge = rxn;
    @(negedge clk);
    bus.go = 1'b0; bus.latch = 1'b0;
    n_tx = txn ? 1 : 0; n_rx = 0;
    checks++;
    if (bus.tip !== 1'b1) begin
      errors++; $display("FAIL %s tip_start got %b exp 1", nm, bus.tip);
    end
    checks++;
    if (bus.lstclk !== (n_tx == L)) begin
      errors++; $display("FAIL %s lstclk_start got %b exp %b", nm, bus.lstclk, n_tx == L);
    end
    if (txn) begin
      checks++;
      if (bus.mosi !== q[0]) begin
        errors++; $display("FAIL %s preload got %b exp %b", nm, bus.mosi, q[0]);
      end
    end
    ph = 0; s = 0; cyc = 0; ndone = 0; aborted = 0; dd = 0;
    while (n_rx < L && !aborted) begin
      if (cyc > 400) begin
        checks++; errors++;
        $display("FAIL %s timeout got %0d bits exp %0d", nm, n_rx, L);
        break;
      end
      c0 = !ph || (s == both_k);
      c1 = ph || (s == both_k);
      bus.cpol_0 = c0; bus.cpol_1 = c1;
      tx = txn ? c1 : c0;
      rx = rxn ? c1 : c0;
      did_tx = tx && (n_tx < L);
      if (rx) begin
        case (miso_mode)
          0: mb = 1'($urandom_range(0, 1));
          1: mb = bus.mosi;
          default: mb = 1'b1;
        endcase
        bus.miso = mb;
        m_reg[bidx(n_rx, L, lsb)] = (miso_mode == 1) ? q[n_rx] : mb;
        n_rx++;
      end
      if (did_tx) n_tx++;
      ph = (c0 && c1) ? 1'b1 : !ph;
      s++;
      @(negedge clk); cyc++;
      bus.cpol_0 = 1'b0; bus.cpol_1 = 1'b0;
      if (did_tx) begin
        checks++;
        if (bus.mosi !== q[n_tx-1]) begin
          errors++;
          $display("FAIL %s mosi bit %0d got %b exp %b", nm, n_tx-1, bus.mosi, q[n_tx-1]);
        end
      end
      checks++;
      if (bus.tip !== (n_rx < L)) begin
        errors++; $display("FAIL %s tip got %b exp %b", nm, bus.tip, n_rx < L);
      end
      checks++;
      if (bus.lstclk !== ((n_rx < L) && (n_tx == L))) begin
        errors++;
        $display("FAIL %s lstclk got %b exp %b", nm, bus.lstclk, (n_rx < L) && (n_tx == L));
      end
      checks++;
      if (bus.done !== (n_rx == L)) begin
        errors++; $display("FAIL %s done got %b exp %b", nm, bus.done, n_rx == L);
      end
      if (bus.done === 1'b1) ndone++;
      if (n_rx == abort_at && n_rx < L) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reg = '0;
        aborted = 1;
        checks++;
        if ({bus.tip, bus.mosi, bus.done, bus.lstclk} !== 4'b0000) begin
          errors++;
          $display("FAIL %s abort_flags got %b%b%b%b exp 0000", nm,
                   bus.tip, bus.mosi, bus.done, bus.lstclk);
        end
        checks++;
        if (bus.p_out !== '0) begin
          errors++; $display("FAIL %s abort_pout got %h exp 0", nm, bus.p_out);
        end
      end else if (disturb && !dd && n_rx < L) begin
        dd = 1;
        bus.go = 1'b1; bus.latch = 1'b1; bus.byte_sel = '1;
        bus.p_in = 32'hDEADBEEF;
        @(negedge clk); cyc++;
        bus.go = 1'b0; bus.latch = 1'b0;
        checks++;
        if (bus.tip !== 1'b1) begin
          errors++; $display("FAIL %s protect_tip got %b exp 1", nm, bus.tip);
        end
      end
      if (n_rx < L && !aborted) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk); cyc++;
          checks++;
          if (bus.tip !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s gap tip/done got %b/%b exp 1/0", nm, bus.tip, bus.done);
          end
        end
      end
    end
    if (!aborted) begin
      checks++;
      if (bus.p_out !== m_reg) begin
        errors++; $display("FAIL %s p_out got %h exp %h", nm, bus.p_out, m_reg);
      end
      checks++;
      if (ndone != 1) begin
        errors++; $display("FAIL %s done_count got %0d exp 1", nm, ndone);
      end
    end
  endtask

  task automatic idle_check(input string nm);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.tip !== 1'b0) begin
      errors++; $display("FAIL %s idle done/tip got %b/%b exp 0/0", nm, bus.done, bus.tip);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.tip, bus.lstclk, bus.done, bus.mosi} !== 4'b0000) begin
      errors++;
      $display("FAIL reset flags got %b%b%b%b exp 0000", bus.tip, bus.lstclk, bus.done, bus.mosi);
    end
    checks++;
    if (bus.p_out !== '0) begin
      errors++; $display("FAIL reset p_out got %h exp 0", bus.p_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_latch();
    logic [MAX_CHAR-1:0] d;
    logic [BSEL_W-1:0] bs;
    for (int i = 0; i < 3; i++) begin
      d = $urandom; bs = BSEL_W'($urandom);
      bus.latch = 1'b1; bus.p_in = d; bus.byte_sel = bs;
      m_reg = merge(m_reg, d, bs);
      @(negedge clk);
      bus.latch = 1'b0;
      checks++;
      if (bus.p_out !== m_reg) begin
        errors++; $display("FAIL latch got %h exp %h", bus.p_out, m_reg);
      end
    end
  endtask

  task automatic test_mode0_a5();
    run_xfer("a5", 32'hA5, 4'b0001, 1, 8, 0, 1, 0, 1, 0, -1, -1);
    checks++;
    if (bus.p_out[7:0] !== 8'hA5) begin
      errors++; $display("FAIL a5 byte got %h exp a5", bus.p_out[7:0]);
    end
    idle_check("a5");
  endtask

  task automatic test_lsb_order();
    run_xfer("lsb4", 32'h1, 4'hF, 1, 4, 1, 1, 0, 2, 0, -1, -1);
    checks++;
    if (bus.p_out[3:0] !== 4'hF) begin
      errors++; $display("FAIL lsb4 nibble got %h exp f", bus.p_out[3:0]);
    end
    idle_check("lsb4");
    run_xfer("len1", $urandom, 4'hF, 1, 1, 0, 1, 0, 0, 0, -1, -1);
    idle_check("len1");
  endtask

  task automatic test_len0();
    run_xfer("len0", 32'hFFFF_0000, 4'hF, 1, 0, 0, 1, 0, 0, 0, -1, -1);
    idle_check("len0");
  endtask

  task automatic test_protect_b2b();
    run_xfer("protect", $urandom, 4'hF, 1, 8, 0, 1, 0, 0, 1, -1, -1);
    run_xfer("b2b", '0, 4'h0, 0, 8, 0, 0, 1, 0, 0, -1, -1);
    idle_check("b2b");
  endtask

  task automatic test_abort();
    run_xfer("abort", $urandom, 4'hF, 1, 8, 0, 1, 0, 0, 0, -1, 3);
    @(negedge clk);
    run_xfer("after_abort", $urandom, 4'hF, 1, 8, 0, 1, 0, 0, 0, -1, -1);
    idle_check("after_abort");
  endtask

  task automatic test_both_strobes();
    run_xfer("both", $urandom, 4'hF, 1, 8, 0, 1, 0, 0, 0, 1, -1);
    idle_check("both");
  endtask

  task automatic test_random();
    bit m;
    for (int i = 0; i < 12; i++) begin
      m = 1'($urandom_range(0, 1));
      run_xfer("rand", $urandom, BSEL_W'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, MAX_CHAR-1), 1'($urandom_range(0, 1)),
               m, !m, 0, 0, -1, -1);
      if ($urandom_range(0, 1) == 1) idle_check("rand");
    end
    idle_check("rand_end");
  endtask

  initial begin
    bus.go = 1'b0; bus.latch = 1'b0; bus.byte_sel = '0; bus.p_in = '0;
    bus.len = '0; bus.lsb = 1'b0; bus.tx_negedge = 1'b0; bus.rx_negedge = 1'b0;
    bus.cpol_0 = 1'b0; bus.cpol_1 = 1'b0; bus.miso = 1'b0;
    test_reset();
    test_latch();
    test_mode0_a5();
    test_lsb_order();
    test_len0();
    test_protect_b2b();
    test_abort();
    test_both_strobes();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
